serial_word_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 20 ++
 rtl/ripple_carry_adder.sv | 33 +++
 rtl/serial_word_adder.sv | 145 ++++++++++++++
 tb/tb_serial_word_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared constants and types for the serial word adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    // Width of one ripple-carry slice processed per clock
    localparam int SLICE_W = 4;

    // Sequencer states of the serial word adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } add_state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder
//  Description : 4-bit ripple-carry adder slice built from full-adder cells.
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    // Carry chain: c[0] is the slice carry-in, c[SLICE_W] the carry-out
    logic [SLICE_W:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit, carry rippling upward
    generate
        for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
            assign sum[i]  = a[i] ^ b[i] ^ c[i];
            assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = c[SLICE_W];

endmodule : ripple_carry_adder
`default_nettype wire

// File: rtl/serial_word_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_adder
//  Description : Multi-cycle WIDTH-bit adder that pushes one 4-bit slice per
//                clock through a shared ripple-carry slice, with valid/ready
//                handshakes on operands and result.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("serial_word_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    add_state_t               state_q, state_d;
    logic [WIDTH-1:0]         a_q, a_d;
    logic [WIDTH-1:0]         b_q, b_d;
    // Completed low slices; the final slice bypasses this register straight
    // into the result, so it only needs WIDTH-SLICE_W bits.
    logic [WIDTH-SLICE_W-1:0] psum_q, psum_d;
    logic                     carry_q, carry_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]         res_sum_q, res_sum_d;
    logic                     res_cout_q, res_cout_d;
    logic                     ovf_q, ovf_d;

    logic [SLICE_W-1:0]       slice_sum;
    logic                     slice_cout;
    logic [WIDTH-1:0]         sum_full;

    ripple_carry_adder u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Newest slice enters at the top; after the last slice this is the word
    assign sum_full = {slice_sum, psum_q};

    // Next-state, datapath shifting and result capture
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        psum_d     = psum_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                psum_d  = sum_full[WIDTH-1:SLICE_W];
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Carry into the MSB differs from carry out of it
                    ovf_d      = a_q[SLICE_W-1] ^ b_q[SLICE_W-1]
                               ^ slice_sum[SLICE_W-1] ^ slice_cout;
                    res_sum_d  = sum_full;
                    res_cout_d = slice_cout;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            psum_q     <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            psum_q     <= psum_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum_out   = res_sum_q;
    assign cout_out  = res_cout_q;
    assign ovf_out   = ovf_q;

endmodule : serial_word_adder
`default_nettype wire

// File: tb/tb_serial_word_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_adder
//  Description : Directed and random self-checking bench for serial_word_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout_out;
    logic         ovf_out;

    int n_assert = 0;
    int n_fail   = 0;

    serial_word_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .cout_out  (cout_out),
        .ovf_out   (ovf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs and samples sit 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand set, then wait (bounded) for out_valid; returns latency
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        cin_in   = c;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (lat >= 50) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Directed transaction with out_ready held high
    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W-1:0] es, input logic ec,
                            input logic eo);
        int lat;
        out_ready = 1'b1;
        issue(a, b, c, lat);
        check({tag, "_lat"},  32'(lat),      32'd4);
        check({tag, "_sum"},  32'(sum_out),  32'(es));
        check({tag, "_cout"}, 32'(cout_out), 32'(ec));
        check({tag, "_ovf"},  32'(ovf_out),  32'(eo));
        step();
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        int          guard;
        logic [W:0]  ref_full;
        logic        ref_ovf;
        logic [W-1:0] ra, rb;
        logic        rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        out_ready = 1'b0;
        #12;

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum_out),   32'd0);
        check("rst_cout",      32'(cout_out),  32'd0);
        check("rst_ovf",       32'(ovf_out),   32'd0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        directed("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("posovf",  16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        directed("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure: result held, new operands refused until handshake
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b0, lat);
        check("bp_lat", 32'(lat), 32'd4);
        in_valid = 1'b1;
        a_in     = 16'hAAAA;
        b_in     = 16'h0000;
        cin_in   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_sum",      32'(sum_out),   32'h5555);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_drop",      32'(out_valid), 32'd0);
        check("bp_idle_rdy",  32'(in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("bp_next_lat", 32'(lat),     32'd4);
        check("bp_next_sum", 32'(sum_out), 32'hAAAA);
        step();

        // Reset in the middle of an addition
        in_valid = 1'b1;
        a_in     = 16'h1234;
        b_in     = 16'h4321;
        cin_in   = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",   32'(sum_out),   32'd0);
        check("mid_rst_cout",  32'(cout_out),  32'd0);
        check("mid_rst_rdy",   32'(in_ready),  32'd0);
        step();
        check("mid_rst_hold",  32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_rdy",  32'(in_ready),  32'd1);
        directed("after_rst", 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Random soak with random result backpressure
        for (int n = 0; n < 175; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            ref_ovf  = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            out_ready = 1'b0;
            issue(ra, rb, rc, lat);
            guard = 0;
            while (guard < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) break;
                step();
                guard++;
            end
            out_ready = 1'b1;
            check("rnd_valid", 32'(out_valid), 32'd1);
            check("rnd_sum",   32'(sum_out),   32'(ref_full[W-1:0]));
            check("rnd_cout",  32'(cout_out),  32'(ref_full[W]));
            check("rnd_ovf",   32'(ovf_out),   32'(ref_ovf));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_serial_word_adder
`default_nettype wire
